// File: rtl/decode_sb_rf.sv
// Decode-stage register file with per-register pending-write scoreboard,
// RAW hazard stall generation and a registered ID/EX pipeline stage.
module decode_sb_rf #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned NREGS        = 8,
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned BYPASS       = 1,
  localparam int unsigned REG_W       = $clog2(NREGS),
  localparam int unsigned CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  input  logic [REG_W-1:0]  rd1_sel,
  input  logic [REG_W-1:0]  rd2_sel,
  input  logic              rd1_use,
  input  logic              rd2_use,
  input  logic [REG_W-1:0]  dst_sel,
  input  logic              dst_wr,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              cancel_en,
  input  logic [REG_W-1:0]  cancel_sel,
  output logic              dec_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rd1_data,
  output logic [DATA_W-1:0] ex_rd2_data,
  output logic [REG_W-1:0]  ex_dst_sel,
  output logic              ex_dst_wr,
  output logic              err
);

  localparam int unsigned SUM_W = CNT_W + 2;

  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];
  logic [CNT_W-1:0]  pend_q [NREGS];
  logic [CNT_W-1:0]  pend_d [NREGS];
  logic [SUM_W-1:0]  up_c [NREGS];
  logic [SUM_W-1:0]  dn_c [NREGS];
  logic              err_q, err_d;
  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_rd1_data_q, ex_rd1_data_d;
  logic [DATA_W-1:0] ex_rd2_data_q, ex_rd2_data_d;
  logic [REG_W-1:0]  ex_dst_sel_q, ex_dst_sel_d;
  logic              ex_dst_wr_q, ex_dst_wr_d;

  logic [DATA_W-1:0] rd1_data_c, rd2_data_c;
  logic              haz1_c, haz2_c, sat_c, stall_c, issue_c;

  // Write-before-read forwarding of the write-back port onto both read ports
  assign rd1_data_c = (wb_en && wb_sel == rd1_sel) ? wb_data : rf_q[rd1_sel];
  assign rd2_data_c = (wb_en && wb_sel == rd2_sel) ? wb_data : rf_q[rd2_sel];

  always_comb begin
    haz1_c = rd1_use && (pend_q[rd1_sel] != '0);
    haz2_c = rd2_use && (pend_q[rd2_sel] != '0);
    // Last pending writer returning this cycle releases the source early
    if (BYPASS != 0 && pend_q[rd1_sel] == CNT_W'(1) && wb_en && wb_sel == rd1_sel) haz1_c = 1'b0;
    if (BYPASS != 0 && pend_q[rd2_sel] == CNT_W'(1) && wb_en && wb_sel == rd2_sel) haz2_c = 1'b0;
    sat_c   = dst_wr && (pend_q[dst_sel] == CNT_W'(MAX_INFLIGHT));
    stall_c = dec_valid && !flush && (haz1_c || haz2_c || sat_c);
    issue_c = dec_valid && !flush && !stall_c;
  end

  assign dec_stall = stall_c;

  // Register file write and scoreboard update; underflow clamps and flags err
  always_comb begin
    err_d = err_q;
    for (int unsigned r = 0; r < NREGS; r++) begin
      rf_d[r] = (wb_en && wb_sel == REG_W'(r)) ? wb_data : rf_q[r];
      up_c[r] = SUM_W'(pend_q[r])
              + SUM_W'(issue_c && dst_wr && dst_sel == REG_W'(r));
      dn_c[r] = SUM_W'(wb_en && wb_sel == REG_W'(r))
              + SUM_W'(cancel_en && cancel_sel == REG_W'(r))
              + SUM_W'(flush && ex_valid_q && ex_dst_wr_q && ex_dst_sel_q == REG_W'(r));
      if (up_c[r] < dn_c[r]) begin
        pend_d[r] = '0;
        err_d     = 1'b1;
      end else begin
        pend_d[r] = CNT_W'(up_c[r] - dn_c[r]);
      end
    end
  end

  // ID/EX stage: bubble unless issuing, payload held otherwise
  always_comb begin
    ex_valid_d    = issue_c;
    ex_rd1_data_d = ex_rd1_data_q;
    ex_rd2_data_d = ex_rd2_data_q;
    ex_dst_sel_d  = ex_dst_sel_q;
    ex_dst_wr_d   = ex_dst_wr_q;
    if (issue_c) begin
      ex_rd1_data_d = rd1_data_c;
      ex_rd2_data_d = rd2_data_c;
      ex_dst_sel_d  = dst_sel;
      ex_dst_wr_d   = dst_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        rf_q[r]   <= '0;
        pend_q[r] <= '0;
      end
      err_q         <= 1'b0;
      ex_valid_q    <= 1'b0;
      ex_rd1_data_q <= '0;
      ex_rd2_data_q <= '0;
      ex_dst_sel_q  <= '0;
      ex_dst_wr_q   <= 1'b0;
    end else begin
      rf_q          <= rf_d;
      pend_q        <= pend_d;
      err_q         <= err_d;
      ex_valid_q    <= ex_valid_d;
      ex_rd1_data_q <= ex_rd1_data_d;
      ex_rd2_data_q <= ex_rd2_data_d;
      ex_dst_sel_q  <= ex_dst_sel_d;
      ex_dst_wr_q   <= ex_dst_wr_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_rd1_data = ex_rd1_data_q;
  assign ex_rd2_data = ex_rd2_data_q;
  assign ex_dst_sel  = ex_dst_sel_q;
  assign ex_dst_wr   = ex_dst_wr_q;
  assign err         = err_q;

endmodule
